// File: rtl/box_pkg.sv
// rtl/box_pkg.sv - shared constants and FSM encoding for the bounding-box packet framer
//
// Purpose : single home for the packet format constants used by box_packer.
// Contents: HEADER_DEF  default first byte of every packet
//           PKT_LEN     bytes per packet
//           IDX_W       width of the byte index
//           LAST_IDX    index of the checksum byte
//           state_t     framer FSM states
package box_pkg;

  localparam logic [7:0] HEADER_DEF = 8'hAA;
  localparam int         PKT_LEN    = 11;
  localparam int         IDX_W      = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/box_packer.sv
// rtl/box_packer.sv - frames a face-seek bounding box into an 11-byte UART packet
//
// Purpose : latch a bounding box on pi_flag and stream it out as
//           HEADER, status, x_min hi/lo, x_max hi/lo, y_min hi/lo, y_max hi/lo,
//           checksum, using a valid/ready byte handshake.
// Ports   : sclk        clock, rising edge
//           rst_n       synchronous active-low reset
//           x_min..y_max  box coordinates, sampled when pi_flag is accepted
//           pi_flag     one-cycle pulse: new box available
//           tx_data     packet byte
//           tx_valid    tx_data valid (equals busy)
//           tx_ready    transmitter accepts the byte this cycle
//           busy        packet in progress
//           overrun     sticky: a box arrived mid-packet and was dropped
//           clr_overrun clears overrun (a simultaneous drop wins)
module box_packer
  import box_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEF,
  parameter int         CNT_W  = 11
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] x_min,
  input  logic [CNT_W-1:0] x_max,
  input  logic [CNT_W-1:0] y_min,
  input  logic [CNT_W-1:0] y_max,
  input  logic             pi_flag,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
);

  // Coordinates are zero-extended to 16 bits before splitting, so the high
  // byte carries c[CNT_W-1:8] with leading zeros.
  function automatic logic [7:0] hi_byte(input logic [CNT_W-1:0] c);
    logic [15:0] e;
    e = 16'(c);
    return e[15:8];
  endfunction

  function automatic logic [7:0] lo_byte(input logic [CNT_W-1:0] c);
    logic [15:0] e;
    e = 16'(c);
    return e[7:0];
  endfunction

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_x_min;
  logic [CNT_W-1:0] r_x_max;
  logic [CNT_W-1:0] r_y_min;
  logic [CNT_W-1:0] r_y_max;
  logic             r_status;
  logic [7:0]       r_csum;
  logic [7:0]       r_tx_data;
  logic             r_overrun;

  logic             w_hs;
  logic             w_last;
  logic             w_accept;
  logic             w_drop;
  logic [7:0]       w_next_byte;

  assign w_hs   = (r_state == ST_SEND) && tx_ready;
  assign w_last = (r_idx == LAST_IDX);

  // A box is taken when idle, or exactly on the checksum handshake so that
  // back-to-back packets run without a gap.
  assign w_accept = pi_flag && ((r_state == ST_IDLE) || (w_hs && w_last));
  assign w_drop   = pi_flag && (r_state == ST_SEND) && !w_accept;

  // Byte presented after the handshake of byte r_idx. r_csum holds the sum of
  // bytes 1..r_idx-1, so the checksum is r_csum plus the last coordinate byte
  // currently on tx_data.
  always_comb begin
    w_next_byte = 8'h00;
    case (r_idx)
      4'd0:    w_next_byte = {7'b0, r_status};
      4'd1:    w_next_byte = hi_byte(r_x_min);
      4'd2:    w_next_byte = lo_byte(r_x_min);
      4'd3:    w_next_byte = hi_byte(r_x_max);
      4'd4:    w_next_byte = lo_byte(r_x_max);
      4'd5:    w_next_byte = hi_byte(r_y_min);
      4'd6:    w_next_byte = lo_byte(r_y_min);
      4'd7:    w_next_byte = hi_byte(r_y_max);
      4'd8:    w_next_byte = lo_byte(r_y_max);
      4'd9:    w_next_byte = r_csum + r_tx_data;
      default: w_next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_x_min   <= '0;
      r_x_max   <= '0;
      r_y_min   <= '0;
      r_y_max   <= '0;
      r_status  <= 1'b0;
      r_csum    <= 8'h00;
      r_tx_data <= 8'h00;
      r_overrun <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end

      if (w_accept) begin
        r_x_min   <= x_min;
        r_x_max   <= x_max;
        r_y_min   <= y_min;
        r_y_max   <= y_max;
        r_status  <= (x_min <= x_max) && (y_min <= y_max);
        r_idx     <= '0;
        r_csum    <= 8'h00;
        r_tx_data <= HEADER;
        r_state   <= ST_SEND;
      end else if (w_hs) begin
        if (w_last) begin
          r_state   <= ST_IDLE;
          r_idx     <= '0;
          r_tx_data <= 8'h00;
        end else begin
          r_idx     <= r_idx + 1'b1;
          r_tx_data <= w_next_byte;
          // Header is excluded from the checksum.
          if (r_idx != '0) begin
            r_csum <= r_csum + r_tx_data;
          end
        end
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign busy     = (r_state == ST_SEND);
  assign tx_valid = busy;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_box_packer.sv
// tb/tb_box_packer.sv - scoreboard bench for box_packer
module tb_box_packer;

  logic        sclk;
  logic        rst_n;
  logic [10:0] x_min, x_max, y_min, y_max;
  logic        pi_flag;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        overrun;
  logic        clr_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  box_packer #(.HEADER(8'hAA), .CNT_W(11)) dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .x_min       (x_min),
    .x_max       (x_max),
    .y_min       (y_min),
    .y_max       (y_max),
    .pi_flag     (pi_flag),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet contents from plain arithmetic, progress tracked
  // as a count of bytes still owed by the transmitter.
  byte unsigned exp_q[$];
  int           rem    = 0;
  logic         exp_ov = 1'b0;

  task automatic push_packet(input int xn, input int xx, input int yn, input int yx);
    int b[10];
    int sum;
    b[0] = 'hAA;
    b[1] = (xn <= xx && yn <= yx) ? 1 : 0;
    b[2] = xn / 256; b[3] = xn % 256;
    b[4] = xx / 256; b[5] = xx % 256;
    b[6] = yn / 256; b[7] = yn % 256;
    b[8] = yx / 256; b[9] = yx % 256;
    sum = 0;
    for (int i = 1; i < 10; i++) sum += b[i];
    for (int i = 0; i < 10; i++) exp_q.push_back(byte'(b[i]));
    exp_q.push_back(byte'(sum % 256));
  endtask

  always @(posedge sclk) begin
    bit hs, acc;
    if (!rst_n) begin
      rem = 0;
      exp_q.delete();
      exp_ov = 1'b0;
    end else begin
      hs  = (rem > 0) && tx_ready;
      acc = pi_flag && (rem == 0 || (rem == 1 && hs));
      if (hs) rem--;
      if (pi_flag && !acc) exp_ov = 1'b1;
      else if (clr_overrun) exp_ov = 1'b0;
      if (acc) begin
        push_packet(int'(x_min), int'(x_max), int'(y_min), int'(y_max));
        rem = 11;
      end
    end
  end

  // Monitor: samples on the falling edge, pops one expected byte per handshake.
  bit         stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always @(negedge sclk) begin
    chk("tx_valid", 32'(tx_valid), 32'(rem > 0));
    chk("busy", 32'(busy), 32'(rem > 0));
    chk("overrun", 32'(overrun), 32'(exp_ov));
    if (tx_valid && stall_pend) chk("stall_hold", 32'(tx_data), 32'(stall_data));
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL byte: got %0h expected no byte at %0t", tx_data, $time);
      end else begin
        chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    stall_pend = tx_valid && !tx_ready;
    stall_data = tx_data;
  end

  task automatic cyc();
    @(posedge sclk);
    #1;
  endtask

  task automatic scramble();
    x_min = 11'($urandom); x_max = 11'($urandom);
    y_min = 11'($urandom); y_max = 11'($urandom);
  endtask

  task automatic pulse(input int xn, input int xx, input int yn, input int yx);
    x_min = 11'(xn); x_max = 11'(xx); y_min = 11'(yn); y_max = 11'(yx);
    pi_flag = 1'b1;
    cyc();
    pi_flag = 1'b0;
    scramble();
  endtask

  task automatic drain();
    int n;
    tx_ready = 1'b1;
    n = 0;
    while (rem > 0 && n < 60) begin
      cyc();
      n++;
    end
    chk("drain_done", 32'(rem), 32'd0);
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; pi_flag = 1'b0; tx_ready = 1'b1; clr_overrun = 1'b0;
    x_min = '0; x_max = '0; y_min = '0; y_max = '0;
    repeat (3) cyc();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Normal box, then empty frame, ready held high.
    pulse(100, 300, 50, 200);
    drain();
    pulse(1023, 0, 755, 0);
    drain();

    // Backpressure on the normal box.
    tx_ready = 1'($urandom);
    pulse(100, 300, 50, 200);
    for (int i = 0; i < 40 && rem > 0; i++) begin
      tx_ready = 1'($urandom);
      cyc();
    end
    drain();

    // Overrun: second box mid-packet is dropped, flag sticks until cleared.
    pulse(100, 300, 50, 200);
    repeat (3) cyc();
    pulse(5, 6, 7, 8);
    drain();
    chk("overrun_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    cyc();
    clr_overrun = 1'b0;
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // Back-to-back: new box on the checksum handshake.
    tx_ready = 1'b1;
    pulse(10, 20, 30, 40);
    repeat (10) cyc();
    pulse(1, 2, 3, 4);
    chk("b2b_header", 32'(tx_data), 32'hAA);
    drain();
    chk("b2b_no_overrun", 32'(overrun), 32'd0);

    // Reset mid-packet with a coincident pi_flag that must be ignored.
    pulse(100, 300, 50, 200);
    repeat (5) cyc();
    rst_n = 1'b0;
    pi_flag = 1'b1;
    cyc();
    rst_n = 1'b1;
    pi_flag = 1'b0;
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    cyc();
    pulse(100, 300, 50, 200);
    drain();

    // Randomised boxes, ready, stray pulses and clears.
    for (int p = 0; p < 8; p++) begin
      pulse(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
            int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
      for (int i = 0; i < 30; i++) begin
        tx_ready    = ($urandom_range(0, 3) != 0);
        pi_flag     = ($urandom_range(0, 9) == 0);
        clr_overrun = ($urandom_range(0, 7) == 0);
        scramble();
        cyc();
      end
      pi_flag = 1'b0;
      clr_overrun = 1'b0;
      drain();
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
